word_serializer: RTL and testbench

WORD_SERIALIZER -- requirements
Module: word_serializer

---
 rtl/word_serializer.sv | 129 ++++++++++++
 tb/tb_word_serializer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/word_serializer.sv
// word_serializer: buffers 4-bit words in a circular FIFO and streams each
// one LSB first as shift strobes for a downstream 4-bit right shift register.
// Latency: a word pushed into an empty FIFO at edge t is popped at edge t+1,
// strobed in cycles t+1..t+4, and word_done pulses in cycle t+5.
// Backpressure: in_ready drops while the FIFO holds FIFO_DEPTH words; hold
// freezes the serializer while the FIFO keeps filling.
//
// Ports:
//   clk, rst              single clock, asynchronous active-high reset
//   in_valid/in_data      upstream word, accepted when in_ready is high
//   in_ready              FIFO not full
//   hold                  pause shifting
//   sr_enable/sr_din      shift strobe and serial bit to downstream register
//   word_done             one-cycle pulse, downstream register holds a full word
//   busy                  serializer in SHIFT state
//   fifo_count            words currently buffered
module word_serializer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [3:0]                    in_data,
  output logic                          in_ready,
  input  logic                          hold,
  output logic                          sr_enable,
  output logic                          sr_din,
  output logic                          word_done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]    state;
  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [3:0]    tx_reg;
  logic [1:0]    bit_cnt;

  logic push;
  logic pop;
  logic last_bit;

  // Full is judged on the pre-edge count, so a full FIFO never passes a
  // word straight through even when a pop happens on the same edge.
  assign in_ready = (fifo_count < DEPTH_C);
  assign push     = in_valid && in_ready;

  // Edge carrying the 4th strobe of the current word.
  assign last_bit = (state == SHIFT) && !hold && (bit_cnt == 2'd3);

  // Pop either to start from IDLE or to chain the next word with no gap.
  assign pop = (fifo_count != '0) && !hold &&
               ((state == IDLE) || last_bit);

  assign busy      = (state == SHIFT);
  assign sr_enable = (state == SHIFT) && !hold;
  assign sr_din    = sr_enable && tx_reg[0];

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      tx_reg     <= '0;
      bit_cnt    <= '0;
      word_done  <= 1'b0;
    end else begin
      // Pointers wrap naturally because FIFO_DEPTH is a power of two.
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + ONE_C;
        2'b01:   fifo_count <= fifo_count - ONE_C;
        default: fifo_count <= fifo_count;
      endcase

      word_done <= last_bit;

      case (state)
        IDLE: begin
          if (pop) begin
            tx_reg  <= mem[rd_ptr];
            bit_cnt <= 2'd0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (!hold) begin
            if (bit_cnt == 2'd3) begin
              bit_cnt <= 2'd0;
              if (pop) begin
                tx_reg <= mem[rd_ptr];
              end else begin
                tx_reg <= '0;
                state  <= IDLE;
              end
            end else begin
              tx_reg  <= {1'b0, tx_reg[3:1]};
              bit_cnt <= bit_cnt + 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
module tb_word_serializer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       hold;
  logic       sr_enable;
  logic       sr_din;
  logic       word_done;
  logic       busy;
  logic [2:0] fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] q;      // downstream right shift register, MSB-side input
  logic [3:0] got[$]; // q captured at each word_done pulse

  word_serializer #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .hold       (hold),
    .sr_enable  (sr_enable),
    .sr_din     (sr_din),
    .word_done  (word_done),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sr_enable) q <= {sr_din, q[3:1]};
  end

  always @(negedge clk) begin
    if (word_done) got.push_back(q);
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_word(input logic [3:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("push_timeout", 8'(n < 100), 8'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Checks strobes for bits first..3 of w, one per cycle.
  task automatic strobe_bits(input logic [3:0] w, input int first);
    for (int i = first; i < 4; i++) begin
      #1;
      chk("strobe_en", 8'(sr_enable), 8'd1);
      chk("strobe_din", 8'(sr_din), 8'(w[i]));
      if (i != first) chk("strobe_wd", 8'(word_done), 8'd0);
      @(negedge clk);
    end
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((fifo_count != 3'd0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 8'(n < 300), 8'd1);
    @(negedge clk);
  endtask

  logic [3:0] exp_wrap [10];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; hold = 1'b0; q = '0;
    exp_wrap = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB};

    // Reset state
    #2;
    chk("rst_en", 8'(sr_enable), 8'd0);
    chk("rst_din", 8'(sr_din), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_wd", 8'(word_done), 8'd0);
    chk("rst_rdy", 8'(in_ready), 8'd1);
    chk("rst_cnt", 8'(fifo_count), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single word 1011 with latency check
    push_word(4'b1011);
    chk("t1_cnt", 8'(fifo_count), 8'd1);
    chk("t1_idle_en", 8'(sr_enable), 8'd0);
    chk("t1_idle_busy", 8'(busy), 8'd0);
    @(negedge clk);
    chk("t1_busy", 8'(busy), 8'd1);
    chk("t1_cnt_pop", 8'(fifo_count), 8'd0);
    strobe_bits(4'b1011, 0);
    chk("t1_wd", 8'(word_done), 8'd1);
    chk("t1_q", 8'(q), 8'hB);
    chk("t1_end_en", 8'(sr_enable), 8'd0);
    chk("t1_end_busy", 8'(busy), 8'd0);
    @(negedge clk);
    chk("t1_wd_off", 8'(word_done), 8'd0);

    // Back-to-back A, 5, C
    in_valid = 1'b1; in_data = 4'hA;
    @(negedge clk);
    in_data = 4'h5;
    chk("t2_cnt1", 8'(fifo_count), 8'd1);
    @(negedge clk);
    in_data = 4'hC;
    chk("t2_cnt_pushpop", 8'(fifo_count), 8'd1);
    chk("t2_a0_en", 8'(sr_enable), 8'd1);
    chk("t2_a0_din", 8'(sr_din), 8'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t2_cnt2", 8'(fifo_count), 8'd2);
    strobe_bits(4'hA, 1);
    chk("t2_wd_a", 8'(word_done), 8'd1);
    chk("t2_q_a", 8'(q), 8'hA);
    strobe_bits(4'h5, 0);
    chk("t2_wd_5", 8'(word_done), 8'd1);
    chk("t2_q_5", 8'(q), 8'h5);
    strobe_bits(4'hC, 0);
    chk("t2_wd_c", 8'(word_done), 8'd1);
    chk("t2_q_c", 8'(q), 8'hC);
    chk("t2_end_en", 8'(sr_enable), 8'd0);
    @(negedge clk);

    // Full and pointer wrap
    hold = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; in_data = 4'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("t3_full_cnt", 8'(fifo_count), 8'd4);
    chk("t3_full_rdy", 8'(in_ready), 8'd0);
    chk("t3_hold_busy", 8'(busy), 8'd0);
    chk("t3_hold_en", 8'(sr_enable), 8'd0);
    got.delete();
    hold = 1'b0;
    @(negedge clk);
    chk("t3_rdy_back", 8'(in_ready), 8'd1);
    chk("t3_cnt3", 8'(fifo_count), 8'd3);
    chk("t3_busy", 8'(busy), 8'd1);
    for (int i = 6; i <= 11; i++) push_word(4'(i));
    wait_drain();
    chk("t3_nwords", 8'(got.size()), 8'd10);
    for (int k = 0; k < 10; k++) begin
      if (k < got.size()) chk($sformatf("t3_word%0d", k), 8'(got[k]), 8'(exp_wrap[k]));
    end

    // Simultaneous push and pop at count 2
    got.delete();
    hold = 1'b1;
    push_word(4'hD);
    push_word(4'hE);
    chk("t4_cnt2", 8'(fifo_count), 8'd2);
    hold = 1'b0; in_valid = 1'b1; in_data = 4'hF;
    @(negedge clk);
    in_valid = 1'b0;
    chk("t4_cnt_stay", 8'(fifo_count), 8'd2);
    chk("t4_busy", 8'(busy), 8'd1);
    wait_drain();
    chk("t4_nwords", 8'(got.size()), 8'd3);
    if (got.size() == 3) begin
      chk("t4_w0", 8'(got[0]), 8'hD);
      chk("t4_w1", 8'(got[1]), 8'hE);
      chk("t4_w2", 8'(got[2]), 8'hF);
    end

    // Hold mid-word: 0110, freeze after 2 strobes for 3 cycles
    push_word(4'h6);
    @(negedge clk);
    #1;
    chk("t5_b0_en", 8'(sr_enable), 8'd1);
    chk("t5_b0_din", 8'(sr_din), 8'd0);
    @(negedge clk);
    #1;
    chk("t5_b1_en", 8'(sr_enable), 8'd1);
    chk("t5_b1_din", 8'(sr_din), 8'd1);
    @(negedge clk);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_hold_en", 8'(sr_enable), 8'd0);
      chk("t5_hold_din", 8'(sr_din), 8'd0);
      chk("t5_hold_busy", 8'(busy), 8'd1);
      @(negedge clk);
    end
    hold = 1'b0;
    strobe_bits(4'h6, 2);
    chk("t5_wd", 8'(word_done), 8'd1);
    chk("t5_q", 8'(q), 8'h6);
    @(negedge clk);

    // Reset mid-word
    in_valid = 1'b1; in_data = 4'hF;
    @(negedge clk);
    in_data = 4'h3;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("t6_s1_en", 8'(sr_enable), 8'd1);
    @(negedge clk);
    #1;
    chk("t6_s2_en", 8'(sr_enable), 8'd1);
    chk("t6_s2_cnt", 8'(fifo_count), 8'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_en", 8'(sr_enable), 8'd0);
    chk("t6_rst_din", 8'(sr_din), 8'd0);
    chk("t6_rst_busy", 8'(busy), 8'd0);
    chk("t6_rst_cnt", 8'(fifo_count), 8'd0);
    chk("t6_rst_rdy", 8'(in_ready), 8'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("t6_no_wd", 8'(word_done), 8'd0);
      chk("t6_idle", 8'(busy), 8'd0);
      @(negedge clk);
    end
    push_word(4'h9);
    @(negedge clk);
    strobe_bits(4'h9, 0);
    chk("t6_wd", 8'(word_done), 8'd1);
    chk("t6_q", 8'(q), 8'h9);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
